// File: rtl/led_pattern_gen.sv
// Programmable-prescaler LED pattern engine (static / blink / chase / count).
// Optional PWM dimming stage is enabled by defining LED_PWM_DIM_EN.
module led_pattern_gen #(
  parameter int               NUM_LEDS    = 8,
  parameter int               DIV_W       = 25,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(25'h1FFFFFF),
  parameter int               PWM_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [DIV_W-1:0]    div_val,
  input  logic                div_load,
  input  logic [1:0]          mode,
  input  logic [NUM_LEDS-1:0] pattern,
`ifdef LED_PWM_DIM_EN
  input  logic [PWM_W-1:0]    duty,
`endif
  output logic                tick,
  output logic [NUM_LEDS-1:0] leds
);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_CHASE  = 2'b10,
    MODE_COUNT  = 2'b11
  } mode_e;

  localparam logic [NUM_LEDS-1:0] LED_ONE = NUM_LEDS'(1);

  logic [DIV_W-1:0]    cnt;
  logic [DIV_W-1:0]    div_q;
  mode_e               mode_q;
  mode_e               mode_in;
  logic [NUM_LEDS-1:0] leds_r;
  logic [NUM_LEDS-1:0] leds_nxt;
  logic [NUM_LEDS-1:0] seed;
  logic                term;
  logic                mode_chg;

  assign mode_in = mode_e'(mode);

  // Prescaler: a pending divisor load always takes precedence over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      div_q <= DEFAULT_DIV;
      tick  <= 1'b0;
    end else if (div_load) begin
      cnt   <= '0;
      div_q <= div_val;
      tick  <= 1'b0;
    end else if (en) begin
      if (cnt == div_q) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + DIV_W'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_STATIC;
      leds_r <= '0;
    end else begin
      mode_q <= mode_in;
      leds_r <= leds_nxt;
    end
  end

  always_comb begin
    term     = en & ~div_load & (cnt == div_q);
    mode_chg = (mode_in != mode_q);

    seed = pattern;
    case (mode_in)
      MODE_CHASE: seed = (pattern == '0) ? LED_ONE : pattern;
      MODE_COUNT: seed = '0;
      default:    seed = pattern;
    endcase

    leds_nxt = leds_r;
    if (mode_chg) begin
      // A mode switch reloads the seed even if a step coincides with it.
      leds_nxt = seed;
    end else begin
      case (mode_q)
        MODE_STATIC: leds_nxt = pattern;
        MODE_BLINK:  if (term) leds_nxt = (leds_r == '0) ? pattern : '0;
        // Shift form keeps a single-LED build a no-op rotate.
        MODE_CHASE:  if (term) leds_nxt = (leds_r << 1) | (leds_r >> (NUM_LEDS - 1));
        MODE_COUNT:  if (term) leds_nxt = leds_r + LED_ONE;
        default:     leds_nxt = leds_r;
      endcase
    end
  end

`ifdef LED_PWM_DIM_EN
  logic [PWM_W-1:0]    pwm_cnt;
  logic [NUM_LEDS-1:0] leds_q;

  // Free-running brightness counter, independent of en and div_load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      leds_q  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      leds_q  <= leds_r & {NUM_LEDS{pwm_cnt < duty}};
    end
  end

  assign leds = leds_q;
`else
  assign leds = leds_r;
`endif

endmodule
